// File: rtl/hdmi_arb_pkg.sv
// Shared types and helpers for the dual-channel HDMI line-fetch arbiter.
package hdmi_arb_pkg;

    typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

    localparam int NUM_CH = 2;

    function automatic int unsigned min_len(input int unsigned remaining,
                                            input int unsigned burst_len);
        return (remaining < burst_len) ? remaining : burst_len;
    endfunction

endpackage

// File: rtl/hdmi_line_fetch_ch.sv
// Per-channel line state: busy flag, address pointer, remaining words,
// plus the overrun and done pulses.
module hdmi_line_fetch_ch #(
    parameter int AW         = 28,
    parameter int LINE_WORDS = 1280,
    parameter int ADDR_STEP  = 2,
    parameter int LW         = 7,
    parameter int RW         = $clog2(LINE_WORDS + 1)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req,
    input  logic [AW-1:0] i_addr,
    input  logic          i_adv,
    input  logic [LW-1:0] i_adv_len,
    input  logic          i_last_beat,
    output logic          o_busy,
    output logic [AW-1:0] o_ptr,
    output logic [RW-1:0] o_remaining,
    output logic          o_done,
    output logic          o_overrun
);

    logic          r_busy;
    logic [AW-1:0] r_ptr;
    logic [RW-1:0] r_rem;
    logic          r_done;
    logic          r_overrun;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_busy    <= 1'b0;
            r_ptr     <= '0;
            r_rem     <= '0;
            r_done    <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_req & r_busy;
            // remaining was already decremented at command accept, so zero here means last burst
            r_done    <= i_last_beat & (r_rem == '0);
            if (i_req && !r_busy) begin
                r_busy <= 1'b1;
                r_ptr  <= i_addr;
                r_rem  <= RW'(LINE_WORDS);
            end else begin
                if (r_done)
                    r_busy <= 1'b0;
                if (i_adv) begin
                    r_ptr <= r_ptr + AW'(i_adv_len) * AW'(ADDR_STEP);
                    r_rem <= r_rem - RW'(i_adv_len);
                end
            end
        end
    end

    assign o_busy      = r_busy;
    assign o_ptr       = r_ptr;
    assign o_remaining = r_rem;
    assign o_done      = r_done;
    assign o_overrun   = r_overrun;

endmodule

// File: rtl/hdmi_line_fetch_arb.sv
// Shares one frame-buffer read port between two HDMI line buffers,
// round-robin per burst, one burst outstanding at a time.
module hdmi_line_fetch_arb
    import hdmi_arb_pkg::*;
#(
    parameter int AW         = 28,
    parameter int DW         = 16,
    parameter int LINE_WORDS = 1280,
    parameter int BURST_LEN  = 64,
    parameter int ADDR_STEP  = 2,
    parameter int LW         = $clog2(BURST_LEN) + 1
) (
    input  logic          pixel_clk,
    input  logic          sys_rst,
    input  logic          ch0_req,
    input  logic [AW-1:0] ch0_addr,
    output logic          ch0_busy,
    output logic          ch0_done,
    output logic          ch0_overrun,
    output logic          ch0_wr_en,
    output logic [DW-1:0] ch0_wr_data,
    input  logic          ch1_req,
    input  logic [AW-1:0] ch1_addr,
    output logic          ch1_busy,
    output logic          ch1_done,
    output logic          ch1_overrun,
    output logic          ch1_wr_en,
    output logic [DW-1:0] ch1_wr_data,
    output logic          mem_cmd_valid,
    input  logic          mem_cmd_ready,
    output logic [AW-1:0] mem_cmd_addr,
    output logic [LW-1:0] mem_cmd_len,
    input  logic          mem_rd_valid,
    input  logic [DW-1:0] mem_rd_data,
    output logic          err_stray
);

    localparam int RW = $clog2(LINE_WORDS + 1);

    logic [NUM_CH-1:0]         w_req, w_busy, w_done, w_ovr, w_adv, w_last, w_elig;
    logic [NUM_CH-1:0][AW-1:0] w_addr_in, w_ptr;
    logic [NUM_CH-1:0][RW-1:0] w_rem;

    state_t                    r_state, w_state_nxt;
    logic                      r_rr, r_gnt, w_sel, w_beat, w_cmd_valid;
    logic [LW-1:0]             r_len, r_beat, w_sel_len;
    logic [AW-1:0]             r_addr;
    logic [NUM_CH-1:0]         r_wr_en;
    logic [NUM_CH-1:0][DW-1:0] r_wr_data;
    logic                      r_err;

    assign w_req     = {ch1_req, ch0_req};
    assign w_addr_in = {ch1_addr, ch0_addr};
    assign w_beat    = (r_state == DATA) && mem_rd_valid;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        assign w_adv[g]  = (r_state == CMD) && mem_cmd_ready && (r_gnt == 1'(g));
        assign w_last[g] = w_beat && (r_beat == LW'(1)) && (r_gnt == 1'(g));
        assign w_elig[g] = w_busy[g] && (w_rem[g] != '0);

        hdmi_line_fetch_ch #(
            .AW(AW), .LINE_WORDS(LINE_WORDS), .ADDR_STEP(ADDR_STEP), .LW(LW), .RW(RW)
        ) u_ch (
            .i_clk       (pixel_clk),
            .i_rst       (sys_rst),
            .i_req       (w_req[g]),
            .i_addr      (w_addr_in[g]),
            .i_adv       (w_adv[g]),
            .i_adv_len   (r_len),
            .i_last_beat (w_last[g]),
            .o_busy      (w_busy[g]),
            .o_ptr       (w_ptr[g]),
            .o_remaining (w_rem[g]),
            .o_done      (w_done[g]),
            .o_overrun   (w_ovr[g])
        );
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cmd_valid = 1'b0;
        // round-robin only matters when both are eligible
        w_sel       = (&w_elig) ? r_rr : ~w_elig[0];
        w_sel_len   = LW'(min_len(32'(w_rem[w_sel]), BURST_LEN));
        case (r_state)
            IDLE: if (|w_elig) w_state_nxt = CMD;
            CMD: begin
                w_cmd_valid = 1'b1;
                if (mem_cmd_ready) w_state_nxt = DATA;
            end
            DATA: if (w_beat && r_beat == LW'(1)) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge pixel_clk) begin
        if (sys_rst) begin
            r_state   <= IDLE;
            r_rr      <= 1'b0;
            r_gnt     <= 1'b0;
            r_len     <= '0;
            r_addr    <= '0;
            r_beat    <= '0;
            r_wr_en   <= '0;
            r_wr_data <= '0;
            r_err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                IDLE: if (|w_elig) begin
                    r_gnt  <= w_sel;
                    r_len  <= w_sel_len;
                    r_addr <= w_ptr[w_sel];
                end
                CMD: if (mem_cmd_ready) r_beat <= r_len;
                DATA: if (mem_rd_valid) begin
                    r_beat <= r_beat - LW'(1);
                    if (r_beat == LW'(1)) r_rr <= ~r_gnt;
                end
                default: ;
            endcase
            if (mem_rd_valid && r_state != DATA) r_err <= 1'b1;
            for (int c = 0; c < NUM_CH; c++) begin
                r_wr_en[c] <= w_beat && (r_gnt == 1'(c));
                if (w_beat && r_gnt == 1'(c)) r_wr_data[c] <= mem_rd_data;
            end
        end
    end

    assign ch0_busy      = w_busy[0];
    assign ch0_done      = w_done[0];
    assign ch0_overrun   = w_ovr[0];
    assign ch0_wr_en     = r_wr_en[0];
    assign ch0_wr_data   = r_wr_data[0];
    assign ch1_busy      = w_busy[1];
    assign ch1_done      = w_done[1];
    assign ch1_overrun   = w_ovr[1];
    assign ch1_wr_en     = r_wr_en[1];
    assign ch1_wr_data   = r_wr_data[1];
    assign mem_cmd_valid = w_cmd_valid;
    assign mem_cmd_addr  = r_addr;
    assign mem_cmd_len   = r_len;
    assign err_stray     = r_err;

endmodule

// File: tb/tb_hdmi_line_fetch_arb.sv
// Directed bench: a LINE_WORDS=128 instance with a reactive memory model and
// a LINE_WORDS=100 instance driven by hand for the short final burst.
module tb_hdmi_line_fetch_arb;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [27:0] addr; logic [6:0] len; } cmd_t;
    typedef struct {
        bit r0; bit r1; logic [27:0] a0; logic [27:0] a1;
        int ncmd; logic [27:0] e0; logic [27:0] e1; logic [27:0] e2; logic [27:0] e3;
    } vec_t;

    // instance A
    logic        rst = 1'b1;
    logic        ch0_req = 0, ch1_req = 0, mem_cmd_ready = 1;
    logic [27:0] ch0_addr = 0, ch1_addr = 0;
    logic        ch0_busy, ch0_done, ch0_overrun, ch0_wr_en;
    logic        ch1_busy, ch1_done, ch1_overrun, ch1_wr_en;
    logic [15:0] ch0_wr_data, ch1_wr_data, mem_rd_data, m_data = 0;
    logic        mem_cmd_valid, mem_rd_valid, err_stray, m_valid = 0, s_valid = 0;
    logic [27:0] mem_cmd_addr;
    logic [6:0]  mem_cmd_len;
    assign mem_rd_valid = m_valid | s_valid;
    assign mem_rd_data  = m_data;

    hdmi_line_fetch_arb #(.AW(28), .DW(16), .LINE_WORDS(128), .BURST_LEN(64), .ADDR_STEP(2)) u_dut (
        .pixel_clk(clk), .sys_rst(rst),
        .ch0_req(ch0_req), .ch0_addr(ch0_addr), .ch0_busy(ch0_busy), .ch0_done(ch0_done),
        .ch0_overrun(ch0_overrun), .ch0_wr_en(ch0_wr_en), .ch0_wr_data(ch0_wr_data),
        .ch1_req(ch1_req), .ch1_addr(ch1_addr), .ch1_busy(ch1_busy), .ch1_done(ch1_done),
        .ch1_overrun(ch1_overrun), .ch1_wr_en(ch1_wr_en), .ch1_wr_data(ch1_wr_data),
        .mem_cmd_valid(mem_cmd_valid), .mem_cmd_ready(mem_cmd_ready), .mem_cmd_addr(mem_cmd_addr),
        .mem_cmd_len(mem_cmd_len), .mem_rd_valid(mem_rd_valid), .mem_rd_data(mem_rd_data),
        .err_stray(err_stray));

    // instance B (short final burst)
    logic        b_req = 0, b_valid = 0, b_zero = 0, b_ready = 1;
    logic [27:0] b_addr = 0, b_zaddr = 0;
    logic [15:0] b_data = 0;
    logic        b0_busy, b0_done, b0_ovr, b0_wr, b1_busy, b1_done, b1_ovr, b1_wr, b_cvalid, b_err;
    logic [15:0] b0_wd, b1_wd;
    logic [27:0] b_caddr;
    logic [6:0]  b_clen;

    hdmi_line_fetch_arb #(.AW(28), .DW(16), .LINE_WORDS(100), .BURST_LEN(64), .ADDR_STEP(2)) u_dut_b (
        .pixel_clk(clk), .sys_rst(rst),
        .ch0_req(b_req), .ch0_addr(b_addr), .ch0_busy(b0_busy), .ch0_done(b0_done),
        .ch0_overrun(b0_ovr), .ch0_wr_en(b0_wr), .ch0_wr_data(b0_wd),
        .ch1_req(b_zero), .ch1_addr(b_zaddr), .ch1_busy(b1_busy), .ch1_done(b1_done),
        .ch1_overrun(b1_ovr), .ch1_wr_en(b1_wr), .ch1_wr_data(b1_wd),
        .mem_cmd_valid(b_cvalid), .mem_cmd_ready(b_ready), .mem_cmd_addr(b_caddr),
        .mem_cmd_len(b_clen), .mem_rd_valid(b_valid), .mem_rd_data(b_data),
        .err_stray(b_err));

    int n_pass = 0, n_tot = 0;
    task automatic chk(input string name, input longint act, input longint exp);
        n_tot++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // monitor: command log, per-channel write counting and data ordering
    cmd_t        cmdq[$];
    logic [27:0] base0 = 0, base1 = 0;
    int idx0 = 0, idx1 = 0, tot0 = 0, tot1 = 0, bad0 = 0, bad1 = 0;
    int ndone0 = 0, ndone1 = 0, at0 = 0, at1 = 0, nov0 = 0, nov1 = 0, lone_done = 0;
    always @(negedge clk) begin
        if (mem_cmd_valid && mem_cmd_ready) cmdq.push_back('{mem_cmd_addr, mem_cmd_len});
        if (ch0_wr_en) begin
            if (ch0_wr_data != 16'((base0 >> 1) + idx0)) bad0++;
            idx0++; tot0++;
        end
        if (ch1_wr_en) begin
            if (ch1_wr_data != 16'((base1 >> 1) + idx1)) bad1++;
            idx1++; tot1++;
        end
        if (ch0_done) begin ndone0++; at0 = idx0; idx0 = 0; if (!ch0_wr_en) lone_done++; end
        if (ch1_done) begin ndone1++; at1 = idx1; idx1 = 0; if (!ch1_wr_en) lone_done++; end
        if (ch0_overrun) nov0++;
        if (ch1_overrun) nov1++;
        if (rst) begin idx0 = 0; idx1 = 0; end
    end

    // memory model for instance A: one burst at a time, data = word address
    initial begin
        logic [27:0] a;
        int          l;
        forever begin
            @(negedge clk);
            if (mem_cmd_valid && mem_cmd_ready && !rst) begin
                a = mem_cmd_addr;
                l = int'(mem_cmd_len);
                for (int i = 0; i < l; i++) begin
                    @(posedge clk); #2;
                    if (rst) begin m_valid = 0; break; end
                    m_valid = 1; m_data = 16'(a[16:1] + i);
                end
                @(posedge clk); #2; m_valid = 0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic req(input bit r0, input bit r1, input logic [27:0] a0, input logic [27:0] a1);
        @(posedge clk); #1;
        ch0_req = r0; ch1_req = r1; ch0_addr = a0; ch1_addr = a1;
        @(posedge clk); #1;
        ch0_req = 0; ch1_req = 0;
    endtask

    task automatic wait_done(input int ch, input int prev, input string nm);
        for (int t = 0; t < 3000; t++) begin
            @(negedge clk); #1;
            if ((ch == 0 ? ndone0 : ndone1) > prev) return;
        end
        chk(nm, 0, 1);
    endtask

    task automatic chk_cmd(input string nm, input int qi, input logic [27:0] ea, input logic [6:0] el);
        cmd_t c;
        c = '{28'h0, 7'h0};
        if (qi < cmdq.size()) c = cmdq[qi];
        chk({nm, "_addr"}, c.addr, ea);
        chk({nm, "_len"}, c.len, el);
    endtask

    task automatic b_burst(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1; b_valid = 1; b_data = 16'(i);
        end
        @(posedge clk); #1; b_valid = 0;
    endtask

    task automatic b_wait_cmd(output bit seen);
        seen = 0;
        for (int t = 0; t < 50 && !seen; t++) begin
            @(negedge clk);
            if (b_cvalid) seen = 1;
        end
    endtask

    vec_t vt[4];
    int   q, d0, d1, s0, s1, o1;
    bit   seen, stable, dseen;
    logic [27:0] e[4];

    initial begin
        vt[0] = '{1, 1, 28'h0000000, 28'h0010000, 4, 28'h0000000, 28'h0010000, 28'h0000080, 28'h0010080};
        vt[1] = '{1, 0, 28'h0001000, 28'h0000000, 2, 28'h0001000, 28'h0001080, 28'h0, 28'h0};
        vt[2] = '{0, 1, 28'h0000000, 28'hFFFFF80, 2, 28'hFFFFF80, 28'h0000000, 28'h0, 28'h0};
        vt[3] = '{1, 1, 28'hFFFFFC0, 28'h0000100, 4, 28'hFFFFFC0, 28'h0000100, 28'h0000040, 28'h0000180};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", {ch0_busy, ch0_done, ch0_overrun, ch0_wr_en, ch0_wr_data,
                              ch1_busy, ch1_done, ch1_overrun, ch1_wr_en, ch1_wr_data,
                              mem_cmd_valid, mem_cmd_addr, mem_cmd_len, err_stray}, 0);
        @(posedge clk); #1 rst = 0;

        // short final burst on the LINE_WORDS=100 instance
        @(posedge clk); #1 b_req = 1; b_addr = 28'h1000;
        @(posedge clk); #1 b_req = 0;
        b_wait_cmd(seen);
        chk("short_cmd0_seen", seen, 1);
        chk("short_cmd0_addr", b_caddr, 28'h1000);
        chk("short_cmd0_len", b_clen, 64);
        b_burst(64);
        b_wait_cmd(seen);
        chk("short_cmd1_seen", seen, 1);
        chk("short_cmd1_addr", b_caddr, 28'h1080);
        chk("short_cmd1_len", b_clen, 36);
        b_burst(36);
        dseen = 0;
        for (int t = 0; t < 5; t++) begin
            @(negedge clk);
            if (b0_done && b0_wr && b0_wd == 16'd35) dseen = 1;
        end
        chk("short_done_with_last_beat", dseen, 1);
        chk("short_no_ch1_write", b1_wr, 0);

        // table-driven line fetches on instance A
        for (int v = 0; v < 4; v++) begin
            base0 = vt[v].a0; base1 = vt[v].a1;
            q = cmdq.size(); d0 = ndone0; d1 = ndone1; s0 = tot0; s1 = tot1;
            e = '{vt[v].e0, vt[v].e1, vt[v].e2, vt[v].e3};
            req(vt[v].r0, vt[v].r1, vt[v].a0, vt[v].a1);
            if (vt[v].r0) wait_done(0, d0, $sformatf("v%0d_ch0_done_timeout", v));
            if (vt[v].r1) wait_done(1, d1, $sformatf("v%0d_ch1_done_timeout", v));
            @(negedge clk);
            chk($sformatf("v%0d_ncmd", v), cmdq.size() - q, vt[v].ncmd);
            for (int i = 0; i < vt[v].ncmd; i++)
                chk_cmd($sformatf("v%0d_cmd%0d", v, i), q + i, e[i], 7'd64);
            chk($sformatf("v%0d_ch0_words", v), tot0 - s0, vt[v].r0 ? 128 : 0);
            chk($sformatf("v%0d_ch1_words", v), tot1 - s1, vt[v].r1 ? 128 : 0);
            chk($sformatf("v%0d_ch0_dones", v), ndone0 - d0, vt[v].r0 ? 1 : 0);
            chk($sformatf("v%0d_ch1_dones", v), ndone1 - d1, vt[v].r1 ? 1 : 0);
            if (vt[v].r0) chk($sformatf("v%0d_ch0_done_at", v), at0, 128);
            if (vt[v].r1) chk($sformatf("v%0d_ch1_done_at", v), at1, 128);
            chk($sformatf("v%0d_busy_cleared", v), {ch0_busy, ch1_busy}, 0);
        end

        // command backpressure, then an overrun request mid-line
        base1 = 28'h2000; q = cmdq.size(); d1 = ndone1; s1 = tot1; o1 = nov1;
        @(posedge clk); #1 mem_cmd_ready = 0;
        req(0, 1, 28'h0, 28'h2000);
        seen = 0;
        for (int t = 0; t < 20 && !seen; t++) begin
            @(negedge clk);
            if (mem_cmd_valid) seen = 1;
        end
        chk("bp_cmd_seen", seen, 1);
        stable = 1;
        for (int t = 0; t < 10; t++) begin
            if (!(mem_cmd_valid && mem_cmd_addr == 28'h2000 && mem_cmd_len == 7'd64)) stable = 0;
            @(negedge clk);
        end
        chk("bp_cmd_stable", stable, 1);
        chk("bp_no_accept_yet", cmdq.size() - q, 0);
        @(posedge clk); #1 mem_cmd_ready = 1;
        for (int t = 0; t < 200 && tot1 - s1 < 20; t++) @(negedge clk);
        req(0, 1, 28'h0, 28'h9000);
        wait_done(1, d1, "ovr_done_timeout");
        @(negedge clk);
        chk("ovr_pulses", nov1 - o1, 1);
        chk("ovr_ncmd", cmdq.size() - q, 2);
        chk_cmd("ovr_cmd0", q, 28'h2000, 7'd64);
        chk_cmd("ovr_cmd1", q + 1, 28'h2080, 7'd64);
        chk("ovr_ch1_words", tot1 - s1, 128);

        // stray read beat while idle
        chk("stray_clear_before", err_stray, 0);
        s0 = tot0; s1 = tot1;
        @(posedge clk); #1 s_valid = 1;
        @(posedge clk); #1 s_valid = 0;
        @(negedge clk);
        chk("stray_set", err_stray, 1);
        repeat (5) @(negedge clk);
        chk("stray_sticky", err_stray, 1);
        chk("stray_discarded", (tot0 - s0) + (tot1 - s1), 0);

        // reset in the middle of a burst
        base0 = 28'h3000; d0 = ndone0; s0 = tot0;
        req(1, 0, 28'h3000, 28'h0);
        for (int t = 0; t < 200 && tot0 - s0 < 10; t++) @(negedge clk);
        chk("rst_mid_reached", tot0 - s0 >= 10, 1);
        @(posedge clk); #1 rst = 1;
        @(posedge clk);
        @(negedge clk);
        chk("rst_mid_outputs", {ch0_busy, ch0_done, ch0_overrun, ch0_wr_en, ch0_wr_data,
                                ch1_busy, ch1_done, ch1_overrun, ch1_wr_en, ch1_wr_data,
                                mem_cmd_valid, mem_cmd_addr, mem_cmd_len, err_stray}, 0);
        @(posedge clk); #1 rst = 0;
        repeat (5) @(negedge clk);
        chk("rst_mid_no_done", ndone0 - d0, 0);
        base0 = 28'h4000; q = cmdq.size(); s0 = tot0;
        req(1, 0, 28'h4000, 28'h0);
        wait_done(0, d0, "rst_new_done_timeout");
        chk_cmd("rst_new_cmd0", q, 28'h4000, 7'd64);
        chk("rst_new_words", tot0 - s0, 128);

        chk("data_order_ch0", bad0, 0);
        chk("data_order_ch1", bad1, 0);
        chk("done_without_wr", lone_done, 0);
        chk("no_ch0_overrun", nov0, 0);

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
